// File: rtl/mult_rom_sequencer_if.sv
// Operand-in / product-out handshake bundle for mult_rom_sequencer.
// slave is the sequencer side; master is the producer/consumer side.
interface mult_rom_sequencer_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N/2-1:0]   op_a;
  logic [N/2-1:0]   op_b;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     result;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, op_count
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, op_count
  );
endinterface

// File: rtl/mult_rom_sequencer.sv
// Front-end sequencer for the multiplication ROM: address/strobe generation, product capture.
// Optional macro ZERO_BYPASS_EN: zero operands skip the ROM access and return 0 directly.
module mult_rom_sequencer #(
  parameter int unsigned N       = 8,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_rom_sequencer_if.slave  bus,
  output logic [N-1:0]         rom_address,
  output logic                 rom_read_en,
  output logic                 rom_ce,
  input  logic [N-1:0]         rom_data
);
  localparam logic [3:0] LastCnt = 4'(ROM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             ce_q;
  logic [N-1:0]     addr_q;
  logic [N-1:0]     result_q;
  logic [CNT_W-1:0] op_count_q;
  logic             accept;
  logic             zero_op;

  assign accept = bus.in_valid && in_ready_q && (state_q == StIdle);

`ifdef ZERO_BYPASS_EN
  assign zero_op = (bus.op_a == '0) || (bus.op_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      ce_q        <= 1'b0;
      addr_q      <= '0;
      result_q    <= '0;
      op_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            if (zero_op) begin
              result_q    <= '0;
              out_valid_q <= 1'b1;
              state_q     <= StDone;
            end else begin
              addr_q  <= {bus.op_a, bus.op_b};
              ce_q    <= 1'b1;
              state_q <= StRead;
            end
          end else begin
            // Covers the first idle cycle after reset, where in_ready is still low.
            in_ready_q <= 1'b1;
          end
        end
        StRead: begin
          if (cnt_q == LastCnt) begin
            result_q    <= rom_data;
            ce_q        <= 1'b0;
            addr_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 1'b1;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.op_count  = op_count_q;
  assign rom_address   = addr_q;
  assign rom_ce        = ce_q;
  assign rom_read_en   = ce_q;
endmodule

// File: tb/tb_mult_rom_sequencer.sv
// Scoreboard bench for mult_rom_sequencer: two instances (ROM_LAT=1 and ROM_LAT=3),
// each with a random driver, a result monitor and a ROM strobe checker.
module tb_mult_rom_sequencer;
  localparam int unsigned N     = 8;
  localparam int unsigned H     = N / 2;
  localparam int unsigned CNT_W = 16;
  localparam int          NumRand = 40;
`ifdef ZERO_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]     res;
    logic [CNT_W-1:0] cnt;
    int               lat;
    int               acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  // Cycles from the handshake cycle to the first cycle with out_valid high.
  function automatic int exp_lat(logic [H-1:0] a, logic [H-1:0] b, int lat);
    return (Bypass && (a == '0 || b == '0)) ? 1 : lat + 1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int Lat = (g == 0) ? 1 : 3;

    logic         rst;
    logic [N-1:0] rom_address;
    logic [N-1:0] rom_data;
    logic         rom_ce;
    logic         rom_read_en;
    exp_t         sb[$];
    int           cyc = 0;
    logic [N-1:0] cur_addr = '0;
    bit           done = 1'b0;

    mult_rom_sequencer_if #(.N(N), .CNT_W(CNT_W)) bus ();

    assign rom_data = N'(rom_address[N-1:H]) * N'(rom_address[H-1:0]);

    mult_rom_sequencer #(.N(N), .ROM_LAT(Lat), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .rom_address(rom_address),
      .rom_read_en(rom_read_en),
      .rom_ce     (rom_ce),
      .rom_data   (rom_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : drive
      logic [H-1:0] qa[$];
      logic [H-1:0] qb[$];
      int n_acc;
      int t;
      qa = '{4'h3, 4'hF, 4'h7, 4'h0, 4'h5, 4'h0};
      qb = '{4'h5, 4'hF, 4'h9, 4'hA, 4'h0, 4'h0};
      for (int i = 0; i < NumRand; i++) begin
        qa.push_back(H'($urandom));
        qb.push_back(H'($urandom));
      end
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      repeat (3) @(negedge clk);
      check($sformatf("L%0d reset in_ready", Lat), 32'(bus.in_ready), 0);
      check($sformatf("L%0d reset out_valid", Lat), 32'(bus.out_valid), 0);
      check($sformatf("L%0d reset result", Lat), 32'(bus.result), 0);
      check($sformatf("L%0d reset op_count", Lat), 32'(bus.op_count), 0);
      check($sformatf("L%0d reset ce", Lat), 32'(rom_ce), 0);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("L%0d in_ready after reset", Lat), 32'(bus.in_ready), 1);

      n_acc = 0;
      t = 0;
      while (qa.size() > 0 && t < 5000) begin
        if (bus.in_ready) begin
          if (qa.size() <= NumRand && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
          end else begin
            bus.in_valid = 1'b1;
            bus.op_a = qa[0];
            bus.op_b = qb[0];
            cur_addr = {qa[0], qb[0]};
            sb.push_back('{res: N'(qa[0]) * N'(qb[0]), cnt: CNT_W'(n_acc),
                           lat: exp_lat(qa[0], qb[0], Lat), acc_cyc: cyc});
            n_acc++;
            void'(qa.pop_front());
            void'(qb.pop_front());
          end
        end else begin
          // Busy: junk requests and operand wiggle must be ignored.
          bus.in_valid = 1'($urandom);
          bus.op_a = H'($urandom);
          bus.op_b = H'($urandom);
        end
        @(negedge clk);
        t++;
      end
      bus.in_valid = 1'b0;
      check($sformatf("L%0d all ops issued", Lat), 32'(qa.size()), 0);

      t = 0;
      while (sb.size() > 0 && t < 200) begin @(negedge clk); t++; end
      check($sformatf("L%0d scoreboard drained", Lat), 32'(sb.size()), 0);
      t = 0;
      while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
      check($sformatf("L%0d ready before abort", Lat), 32'(bus.in_ready), 1);

      // Abort an access mid-READ; nothing goes into the scoreboard for it.
      bus.in_valid = 1'b1;
      bus.op_a = 4'h6;
      bus.op_b = 4'h6;
      cur_addr = 8'h66;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("L%0d ce during read", Lat), 32'(rom_ce), 1);
      rst = 1'b1;
      @(negedge clk);
      check($sformatf("L%0d abort ce", Lat), 32'(rom_ce), 0);
      check($sformatf("L%0d abort read_en", Lat), 32'(rom_read_en), 0);
      check($sformatf("L%0d abort address", Lat), 32'(rom_address), 0);
      check($sformatf("L%0d abort out_valid", Lat), 32'(bus.out_valid), 0);
      check($sformatf("L%0d abort in_ready", Lat), 32'(bus.in_ready), 0);
      check($sformatf("L%0d abort op_count", Lat), 32'(bus.op_count), 0);
      rst = 1'b0;
      @(negedge clk);
      check($sformatf("L%0d ready after abort", Lat), 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.op_a = 4'h2;
      bus.op_b = 4'h3;
      cur_addr = 8'h23;
      sb.push_back('{res: 8'h06, cnt: '0, lat: Lat + 1, acc_cyc: cyc});
      @(negedge clk);
      bus.in_valid = 1'b0;
      t = 0;
      while (sb.size() > 0 && t < 200) begin @(negedge clk); t++; end
      check($sformatf("L%0d final drain", Lat), 32'(sb.size()), 0);
      done = 1'b1;
    end

    initial begin : monitor
      int   hold;
      int   n_out;
      bit   seen;
      exp_t e;
      hold = 0;
      n_out = 0;
      seen = 1'b0;
      bus.out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          seen = 1'b0;
          bus.out_ready = 1'b0;
        end else if (bus.out_valid) begin
          if (sb.size() == 0) begin
            check($sformatf("L%0d unexpected out_valid", Lat), 32'(bus.out_valid), 0);
            bus.out_ready = 1'b1;
          end else begin
            e = sb[0];
            if (!seen) begin
              seen = 1'b1;
              check($sformatf("L%0d latency", Lat), 32'(cyc - e.acc_cyc), 32'(e.lat));
              hold = (n_out == 1) ? 4 : $urandom_range(0, 2);
            end
            check($sformatf("L%0d result", Lat), 32'(bus.result), 32'(e.res));
            check($sformatf("L%0d op_count", Lat), 32'(bus.op_count), 32'(e.cnt));
            check($sformatf("L%0d in_ready in DONE", Lat), 32'(bus.in_ready), 0);
            if (hold == 0) begin
              bus.out_ready = 1'b1;
              void'(sb.pop_front());
              seen = 1'b0;
              n_out++;
            end else begin
              bus.out_ready = 1'b0;
              hold--;
            end
          end
        end else begin
          bus.out_ready = 1'($urandom);
        end
      end
    end

    initial begin : strobe
      int w;
      w = 0;
      forever begin
        @(negedge clk);
        check($sformatf("L%0d read_en tracks ce", Lat), 32'(rom_read_en), 32'(rom_ce));
        if (!rom_ce) check($sformatf("L%0d idle address", Lat), 32'(rom_address), 0);
        else check($sformatf("L%0d strobe address", Lat), 32'(rom_address), 32'(cur_addr));
        if (rst) begin
          w = 0;
        end else if (rom_ce) begin
          w++;
        end else if (w > 0) begin
          check($sformatf("L%0d strobe width", Lat), 32'(w), 32'(Lat));
          w = 0;
        end
      end
    end
  end

  initial begin : top
    int t;
    t = 0;
    while (!(g_dut[0].done && g_dut[1].done) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drivers finished", 32'(g_dut[0].done && g_dut[1].done), 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
